flex_nbyte_packer: RTL and testbench
====================================

FLEX_NBYTE_PACKER -- requirements
Module: flex_nbyte_packer

Interface
REQ-001 Parameter BYTE_W, default 8, bits per input symbol.
REQ-002 Parameter NUM_BYTES, default 6, symbols per output word; legal range 2..32.
REQ-003 Parameter SHIFT_MSB, default 1; 1 = shift toward MSB (new symbol enters bits [BYTE_W-1:0]), 0 = shift toward LSB (new symbol enters top BYTE_W bits).
REQ-004 Localparam CNT_W = $clog2(NUM_BYTES+1).
REQ-005 clk  input  1  rising-edge clock, sole clock domain.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  in_data holds a symbol this cycle.
REQ-008 in_data  input  BYTE_W  symbol to pack.
REQ-009 in_ready  output  1  packer accepts a symbol this cycle.
REQ-010 flush  input  1  close the current partial word.
REQ-011 out_valid  output  1  out_data/out_count hold a completed word.
REQ-012 out_ready  input  1  consumer takes the word this cycle.
REQ-013 out_data  output  NUM_BYTES*BYTE_W  packed word.
REQ-014 out_count  output  CNT_W  number of valid symbols in out_data (1..NUM_BYTES when out_valid).

Function
REQ-015 Two states: FILL, HOLD; in_ready = (state==FILL); out_valid = (state==HOLD).
REQ-016 Accept = in_valid & in_ready; on accept, shift register shifts one symbol per REQ-003 and count increments.
REQ-017 FILL->HOLD on accept when count == NUM_BYTES-1; out_valid rises the next cycle with out_count = NUM_BYTES.
REQ-018 FILL->HOLD on flush when count > 0, or count == 0 with simultaneous accept; the accepted symbol is included in the word.
REQ-019 flush with count == 0 and no accept: ignored, no state change.
REQ-020 flush in HOLD: ignored.
REQ-021 HOLD->FILL on out_ready; shift register and count clear to 0 on that edge.
REQ-022 out_data and out_count stable for the whole of HOLD; in_valid/in_data ignored in HOLD (except REQ-027).
REQ-023 Partial word: unfilled symbol slots read 0; received symbols sit in the low slots (SHIFT_MSB=1) or high slots (SHIFT_MSB=0), oldest farthest from entry point.
REQ-024 Latency: last symbol accepted at edge N -> out_valid high in cycle N+1; no combinational path from in_* to out_*.
REQ-025 Throughput without REQ-027: NUM_BYTES accept cycles + 1 HOLD cycle per word minimum.

Reset
REQ-026 While rst high at a rising edge: state = FILL, count = 0, shift register = 0; hence in_ready=1, out_valid=0, out_data=0, out_count=0 next cycle; rst overrides any simultaneous accept, flush or out_ready, and aborts a partial or held word with no output.

Configuration
REQ-027 Macro FLEX_PACKER_BYPASS_EN defined: in HOLD, in_ready = out_ready; a symbol offered while the word is consumed becomes slot 0 of the next word (count=1, state FILL, or HOLD directly if NUM_BYTES==1 is excluded by REQ-002) -- zero-bubble streaming.
REQ-028 Macro undefined: in_ready strictly 0 in HOLD; one bubble cycle per word per REQ-025.

Verification
REQ-029 BYTE_W=8, NUM_BYTES=6, SHIFT_MSB=1; feed 0x11..0x66 back-to-back, out_ready=1 -> out_data=0x112233445566, out_count=6, out_valid for exactly 1 cycle.
REQ-030 Same with SHIFT_MSB=0 -> out_data=0x665544332211.
REQ-031 Feed 0xA1,0xB2 then flush, out_ready=0 for 5 cycles -> out_valid held 5+ cycles, out_data=0x00000000A1B2, out_count=2, in_ready=0 throughout.
REQ-032 Flush with count 0 -> no out_valid; flush on same cycle as 3rd symbol 0xC3 after 0xA1,0xB2 -> out_count=3, out_data=0x000000A1B2C3.
REQ-033 rst pulsed after 4 symbols accepted, then 6 new symbols -> only one word emitted, containing solely the 6 post-reset symbols.
REQ-034 FLEX_PACKER_BYPASS_EN defined, continuous in_valid and out_ready=1 over 24 symbols -> 4 words, in_ready never low; undefined -> 4 words with in_ready low exactly 1 cycle per word.

Source files
------------

// File: rtl/flex_nbyte_packer_if.sv
// Stream bundle for flex_nbyte_packer: symbol input side, flush request and
// packed-word output side. The master drives symbols and consumes words; the
// packer sits on the slave modport.
interface flex_nbyte_packer_if #(
    parameter int BYTE_W    = 8,
    parameter int NUM_BYTES = 6
);
    localparam int CNT_W = $clog2(NUM_BYTES + 1);

    logic                        in_valid;
    logic [BYTE_W-1:0]           in_data;
    logic                        in_ready;
    logic                        flush;
    logic                        out_valid;
    logic                        out_ready;
    logic [NUM_BYTES*BYTE_W-1:0] out_data;
    logic [CNT_W-1:0]            out_count;

    modport master (
        output in_valid,
        output in_data,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_count
    );
endinterface

// File: rtl/flex_nbyte_packer.sv
// flex_nbyte_packer: collects BYTE_W-bit symbols into a NUM_BYTES-symbol word
// through a shift register, then holds the word until the consumer takes it.
// A flush closes a partial word early; unfilled slots read as zero.
// Optional feature macro FLEX_PACKER_BYPASS_EN: while a held word is being
// consumed, a new symbol may be accepted in the same cycle and becomes the
// first symbol of the next word (zero-bubble streaming). Without the macro the
// packer refuses input for the whole hold period.
module flex_nbyte_packer #(
    parameter int BYTE_W    = 8,
    parameter int NUM_BYTES = 6,
    parameter int SHIFT_MSB = 1
) (
    input  logic               clk,
    input  logic               rst,
    flex_nbyte_packer_if.slave bus
);
    localparam int               CNT_W    = $clog2(NUM_BYTES + 1);
    localparam int               WORD_W   = NUM_BYTES * BYTE_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_in_ready;
    logic              w_accept;

    // Push one symbol in at the entry end; the oldest symbol drifts toward the
    // far end so arrival order reads naturally across the word.
    function automatic logic [WORD_W-1:0] shift_in(
        input logic [WORD_W-1:0] word,
        input logic [BYTE_W-1:0] sym
    );
        logic [WORD_W-1:0] res;
        if (SHIFT_MSB != 0) begin
            res = (word << BYTE_W) | WORD_W'(sym);
        end else begin
            res = (word >> BYTE_W) | {sym, {(WORD_W-BYTE_W){1'b0}}};
        end
        return res;
    endfunction

    // Next-state logic: accept/flush handling in FILL, hand-off in HOLD.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        w_in_ready  = (r_state == S_FILL);
`ifdef FLEX_PACKER_BYPASS_EN
        if (r_state == S_HOLD) begin
            w_in_ready = bus.out_ready;
        end
`endif
        w_accept = bus.in_valid & w_in_ready;

        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    w_shift_nxt = shift_in(r_shift, bus.in_data);
                    w_count_nxt = r_count + ONE_CNT;
                    // A flush together with a symbol closes the word including it.
                    if ((r_count == LAST_CNT) || bus.flush) begin
                        w_state_nxt = S_HOLD;
                    end
                end else if (bus.flush && (r_count != '0)) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // Flush is meaningless here; only the consumer releases the word.
                if (bus.out_ready) begin
                    w_state_nxt = S_FILL;
                    w_shift_nxt = '0;
                    w_count_nxt = '0;
                    // Only reachable in the bypass build: the new symbol seeds
                    // an otherwise empty word.
                    if (w_accept) begin
                        w_shift_nxt = shift_in({WORD_W{1'b0}}, bus.in_data);
                        w_count_nxt = ONE_CNT;
                    end
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // State, shift register and symbol count; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
            r_shift <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Outputs come straight from registers so nothing on the input side
    // reaches out_* combinationally.
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.out_data  = r_shift;
    assign bus.out_count = r_count;

endmodule

// File: tb/tb_flex_nbyte_packer.sv
// Self-checking bench for flex_nbyte_packer. Two instances (entry at LSB and
// entry at MSB) share one stimulus stream; a queue-based word model predicts
// handshakes and packed words for both.
module tb_flex_nbyte_packer;
    localparam int BW = 8;
    localparam int NB = 6;
    localparam int WW = NB * BW;
    localparam int CW = $clog2(NB + 1);
`ifdef FLEX_PACKER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic [BW-1:0] in_data   = '0;
    logic          flush     = 1'b0;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    flex_nbyte_packer_if #(.BYTE_W(BW), .NUM_BYTES(NB)) bus_m ();
    flex_nbyte_packer_if #(.BYTE_W(BW), .NUM_BYTES(NB)) bus_l ();

    assign bus_m.in_valid  = in_valid;
    assign bus_m.in_data   = in_data;
    assign bus_m.flush     = flush;
    assign bus_m.out_ready = out_ready;
    assign bus_l.in_valid  = in_valid;
    assign bus_l.in_data   = in_data;
    assign bus_l.flush     = flush;
    assign bus_l.out_ready = out_ready;

    flex_nbyte_packer #(.BYTE_W(BW), .NUM_BYTES(NB), .SHIFT_MSB(1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    flex_nbyte_packer #(.BYTE_W(BW), .NUM_BYTES(NB), .SHIFT_MSB(0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: queue of symbols of the open word ----
    logic [BW-1:0] m_syms[$];
    bit            m_hold    = 1'b0;
    bit            model_chk = 1'b0;

    function automatic logic [WW-1:0] m_pack(input bit msb_entry);
        logic [WW-1:0] w;
        int n;
        w = '0;
        n = m_syms.size();
        for (int i = 0; i < n; i++) begin
            if (msb_entry) w = w | (WW'(m_syms[i]) << (BW * (n - 1 - i)));
            else           w = w | (WW'(m_syms[i]) << (BW * (NB - n + i)));
        end
        return w;
    endfunction

    task automatic model_check();
        logic exp_ir;
        exp_ir = !m_hold || (BYP && out_ready);
        chk("mdl_in_ready_msb",  64'(bus_m.in_ready),  64'(exp_ir));
        chk("mdl_in_ready_lsb",  64'(bus_l.in_ready),  64'(exp_ir));
        chk("mdl_out_valid_msb", 64'(bus_m.out_valid), 64'(m_hold));
        chk("mdl_out_valid_lsb", 64'(bus_l.out_valid), 64'(m_hold));
        if (m_hold) begin
            chk("mdl_out_data_msb",  64'(bus_m.out_data),  64'(m_pack(1'b1)));
            chk("mdl_out_data_lsb",  64'(bus_l.out_data),  64'(m_pack(1'b0)));
            chk("mdl_out_count_msb", 64'(bus_m.out_count), 64'(m_syms.size()));
            chk("mdl_out_count_lsb", 64'(bus_l.out_count), 64'(m_syms.size()));
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_syms.delete();
            m_hold = 1'b0;
        end else if (!m_hold) begin
            if (in_valid) m_syms.push_back(in_data);
            if ((m_syms.size() == NB) || (flush && (m_syms.size() > 0))) m_hold = 1'b1;
        end else if (out_ready) begin
            m_syms.delete();
            m_hold = 1'b0;
            if (BYP && in_valid) m_syms.push_back(in_data);
        end
    endtask

    // Samples taken at the falling edge of the last cycle.
    logic          s_ir_m, s_ov_m, s_ir_l, s_ov_l;
    logic [WW-1:0] s_dm, s_dl;
    logic [CW-1:0] s_cm, s_cl;

    task automatic cyc();
        @(negedge clk);
        if (model_chk) model_check();
        s_ir_m = bus_m.in_ready;
        s_ov_m = bus_m.out_valid;
        s_dm   = bus_m.out_data;
        s_cm   = bus_m.out_count;
        s_ir_l = bus_l.in_ready;
        s_ov_l = bus_l.out_valid;
        s_dl   = bus_l.out_data;
        s_cl   = bus_l.out_count;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          v;
        logic [BW-1:0] d;
        logic          fl;
        logic          ordy;
        logic          ir;
        logic          ov;
        logic [WW-1:0] dm;
        logic [WW-1:0] dl;
        logic [CW-1:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [BW-1:0] d, input logic fl,
                                input logic ordy, input logic ir, input logic ov,
                                input logic [WW-1:0] dm, input logic [WW-1:0] dl,
                                input logic [CW-1:0] cnt);
        vec_t r;
        r.v = v; r.d = d; r.fl = fl; r.ordy = ordy;
        r.ir = ir; r.ov = ov; r.dm = dm; r.dl = dl; r.cnt = cnt;
        return r;
    endfunction

    vec_t tbl[25];

    initial begin
        int sent;
        int words;
        int lows;
        logic [WW-1:0] wdm, wdl;
        logic [CW-1:0] wcnt;

        // full word, back-to-back, consumed at once
        tbl[0]  = mk(1, 8'h11, 0, 0, 1, 0, '0, '0, '0);
        tbl[1]  = mk(1, 8'h22, 0, 0, 1, 0, '0, '0, '0);
        tbl[2]  = mk(1, 8'h33, 0, 0, 1, 0, '0, '0, '0);
        tbl[3]  = mk(1, 8'h44, 0, 0, 1, 0, '0, '0, '0);
        tbl[4]  = mk(1, 8'h55, 0, 0, 1, 0, '0, '0, '0);
        tbl[5]  = mk(1, 8'h66, 0, 0, 1, 0, '0, '0, '0);
        tbl[6]  = mk(0, 8'h00, 0, 1, BYP, 1, 48'h112233445566, 48'h665544332211, 3'd6);
        tbl[7]  = mk(0, 8'h00, 0, 0, 1, 0, '0, '0, '0);
        // two symbols, separate flush, consumer stalls five cycles
        tbl[8]  = mk(1, 8'hA1, 0, 0, 1, 0, '0, '0, '0);
        tbl[9]  = mk(1, 8'hB2, 0, 0, 1, 0, '0, '0, '0);
        tbl[10] = mk(0, 8'h00, 1, 0, 1, 0, '0, '0, '0);
        for (int i = 11; i <= 15; i++)
            tbl[i] = mk(0, 8'h00, 0, 0, 0, 1, 48'h0000_0000_A1B2, 48'hB2A1_0000_0000, 3'd2);
        tbl[16] = mk(0, 8'h00, 0, 1, BYP, 1, 48'h0000_0000_A1B2, 48'hB2A1_0000_0000, 3'd2);
        tbl[17] = mk(0, 8'h00, 0, 0, 1, 0, '0, '0, '0);
        // flush on empty word is ignored; flush with the third symbol includes it
        tbl[18] = mk(0, 8'h00, 1, 0, 1, 0, '0, '0, '0);
        tbl[19] = mk(0, 8'h00, 0, 0, 1, 0, '0, '0, '0);
        tbl[20] = mk(1, 8'hA1, 0, 0, 1, 0, '0, '0, '0);
        tbl[21] = mk(1, 8'hB2, 0, 0, 1, 0, '0, '0, '0);
        tbl[22] = mk(1, 8'hC3, 1, 0, 1, 0, '0, '0, '0);
        tbl[23] = mk(0, 8'h00, 0, 1, BYP, 1, 48'h0000_00A1_B2C3, 48'hC3B2_A100_0000, 3'd3);
        tbl[24] = mk(0, 8'h00, 0, 0, 1, 0, '0, '0, '0);

        // reset, with traffic offered that must be ignored
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; flush = 1'b1; out_ready = 1'b1;
        cyc();
        cyc();
        chk("rst_in_ready_msb",  64'(s_ir_m), 64'd1);
        chk("rst_out_valid_msb", 64'(s_ov_m), 64'd0);
        chk("rst_out_data_msb",  64'(s_dm),   64'd0);
        chk("rst_out_count_msb", 64'(s_cm),   64'd0);
        chk("rst_in_ready_lsb",  64'(s_ir_l), 64'd1);
        chk("rst_out_valid_lsb", 64'(s_ov_l), 64'd0);
        chk("rst_out_data_lsb",  64'(s_dl),   64'd0);
        chk("rst_out_count_lsb", 64'(s_cl),   64'd0);
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        model_chk = 1'b1;

        for (int i = 0; i < 25; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; flush = tbl[i].fl; out_ready = tbl[i].ordy;
            cyc();
            chk($sformatf("tbl%0d_in_ready", i),  64'(s_ir_m), 64'(tbl[i].ir));
            chk($sformatf("tbl%0d_out_valid", i), 64'(s_ov_m), 64'(tbl[i].ov));
            chk($sformatf("tbl%0d_out_valid_lsb", i), 64'(s_ov_l), 64'(tbl[i].ov));
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d_out_data_msb", i), 64'(s_dm), 64'(tbl[i].dm));
                chk($sformatf("tbl%0d_out_data_lsb", i), 64'(s_dl), 64'(tbl[i].dl));
                chk($sformatf("tbl%0d_out_count", i),    64'(s_cm), 64'(tbl[i].cnt));
            end
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

        // reset in the middle of a partial word drops it entirely
        words = 0; wdm = '0; wdl = '0; wcnt = '0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i + 1);
            cyc();
            if (s_ov_m) words++;
        end
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; flush = 1'b1;
        cyc();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        sent = 0;
        for (int c = 0; c < 15; c++) begin
            in_valid = (sent < 6);
            in_data  = 8'(8'h51 + sent);
            cyc();
            if (in_valid && s_ir_m) sent++;
            if (s_ov_m && out_ready) begin
                words++; wdm = s_dm; wdl = s_dl; wcnt = s_cm;
            end
        end
        chk("rstmid_words",    64'(words), 64'd1);
        chk("rstmid_data_msb", 64'(wdm),   64'h5152_5354_5556);
        chk("rstmid_data_lsb", 64'(wdl),   64'h5655_5453_5251);
        chk("rstmid_count",    64'(wcnt),  64'd6);

        // continuous streaming of 24 symbols
        in_valid = 1'b0; out_ready = 1'b1;
        sent = 0; words = 0; lows = 0;
        for (int c = 0; (c < 100) && (words < 4); c++) begin
            in_valid = (sent < 24);
            in_data  = 8'(sent + 1);
            cyc();
            if (in_valid && s_ir_m) sent++;
            if (!s_ir_m) lows++;
            if (s_ov_m) words++;
        end
        chk("stream_words",    64'(words), 64'd4);
        chk("stream_sent",     64'(sent),  64'd24);
        chk("stream_ir_lows",  64'(lows),  BYP ? 64'd0 : 64'd4);

        // randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            flush     = ($urandom_range(0, 11) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
